video_timing: RTL and testbench
===============================

Name: video_timing

Overview:
- Raster timing generator directly upstream of the character map stage.
- Produces the pixel clock enable and the hcnt/vcnt raster counters that the character map consumes to form its RAM and ROM addresses.
- Produces sync, blank and data-enable, delayed to line up with the character map's RAM/ROM read latency, plus a frame counter and a vblank interrupt strobe for the CPU.
- 320x240 visible area at 15 kHz by default: 40x30 character cells of 8x8.

Parameters:
- CE_DIV, 2, clk cycles per pixel; 1 means ce_pix is held high.
- H_VISIBLE, 320, active pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 32, hsync width in pixels.
- H_BP, 32, horizontal back porch; H_TOTAL = sum of the four = 400, which must be ≤ 512.
- V_VISIBLE, 240, active lines.
- V_FP, 3, vertical front porch in lines.
- V_SYNC, 4, vsync width in lines.
- V_BP, 15, vertical back porch; V_TOTAL = 262, which must be ≤ 512.
- SYNC_POL, 0, active level of hsync and vsync (0 = active-low).
- PIPE_DELAY, 2, pixel ticks by which hsync/vsync/hblank/vblank/de lag hcnt/vcnt; range 0..7.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ce_pix  out  1  pixel enable, one clk wide.
- hcnt  out  9  horizontal pixel counter.
- vcnt  out  9  line counter.
- hsync  out  1  delayed horizontal sync, polarity SYNC_POL.
- vsync  out  1  delayed vertical sync, polarity SYNC_POL.
- hblank  out  1  delayed horizontal blank.
- vblank  out  1  delayed vertical blank.
- de  out  1  delayed data enable, equal to ~hblank & ~vblank.
- frame  out  16  frame counter.
- vblank_irq  out  1  one-clk strobe at vblank entry.

Behaviour:
- Reset (reset low, asynchronous): all state clears.
  - Divider = 0, ce_pix = 0, hcnt = 0, vcnt = 0, frame = 0, vblank_irq = 0.
  - hblank = 1, vblank = 1, de = 0; hsync and vsync at their inactive level (~SYNC_POL).
  - Every delay-line stage resets to these same values.
- Reset mid-frame: same result, and the raster restarts from hcnt = 0, vcnt = 0.
- Divider:
  - Counts 0..CE_DIV-1 on every clk.
  - ce_pix is registered, high for the one clk after the divider reads CE_DIV-1.
  - The first ce_pix after reset release occurs on clk edge CE_DIV.
  - CE_DIV = 1: ce_pix goes high on the first edge and stays high.
- Counters, updated only on clks where ce_pix = 1:
  - hcnt increments by 1.
  - At hcnt = H_TOTAL-1, hcnt wraps to 0 and vcnt increments.
  - At vcnt = V_TOTAL-1 together with the hcnt wrap, vcnt wraps to 0 and frame increments (modulo 2^16).
- Raw flags, registered in the same cycle as the counters so they are aligned with the new hcnt/vcnt:
  - hb_raw = hcnt ≥ H_VISIBLE.
  - vb_raw = vcnt ≥ V_VISIBLE.
  - hs_raw = H_VISIBLE+H_FP ≤ hcnt < H_VISIBLE+H_FP+H_SYNC.
  - vs_raw = V_VISIBLE+V_FP ≤ vcnt < V_VISIBLE+V_FP+V_SYNC.
  - vsync changes at hcnt = 0, not at the horizontal sync edge.
- Delay line:
  - hs/vs/hb/vb raw flags pass through a PIPE_DELAY-stage shift register that advances only when ce_pix = 1.
  - PIPE_DELAY = 0: outputs are the raw flags directly.
  - de is formed from the delayed hblank and vblank.
- vblank_irq:
  - High for exactly one clk, on the ce_pix clk where vcnt changes from V_VISIBLE-1 to V_VISIBLE.
  - Not delayed.
  - Does not fire during reset or on the reset release edge.
- Output widths:
  - hcnt and vcnt are 9 bits.
  - Comparisons are unsigned, evaluated on 10-bit sums so that parameter sums cannot overflow.
- Parameter checks at elaboration: H_TOTAL > 512, V_TOTAL > 512 or PIPE_DELAY > 7 raises an error.

Decomposition:
- Package video_timing_pkg holds:
  - default timing constants (visible, porch and sync values);
  - derived H_TOTAL, V_TOTAL and the sync start/end constants;
  - a packed struct {hs, vs, hb, vb} used as the delay-line element.
- Sub-module sync_delay: generic PIPE_DELAY-deep shift register.
  - Ports: clk, reset, ce, packed struct input and output.
  - Reset value is set by a parameter.

Test Plan:
- Reset release, CE_DIV = 2: ce_pix first high on clk edge 2, then every 2nd clk. hcnt goes 0→1 on the first ce tick; hblank = 1 and vblank = 1 until the delayed flags first update.
- Full line, PIPE_DELAY = 0: hblank rises at hcnt = 320. hsync is low for hcnt 336..367 (32 ticks). hcnt wraps 399→0 and vcnt increments on that same tick.
- Full frame: vblank is high for vcnt 240..261. vsync is low for vcnt 243..246, changing at hcnt = 0. vcnt wraps 261→0 and frame increments 0→1. vblank_irq pulses exactly once per frame, 1 clk wide, at vcnt 239→240.
- PIPE_DELAY = 2: every hblank/hsync/de edge lags the PIPE_DELAY = 0 edge by exactly 2 ce_pix ticks (4 clks at CE_DIV = 2).
- Reset asserted mid-frame at hcnt = 150, vcnt = 100: all outputs go to their reset values immediately, without a clk edge. After release the raster restarts from 0,0 and frame = 0.
- CE_DIV = 1: ce_pix stays high; one frame takes 400*262 = 104800 clks. frame = 0xFFFF wraps to 0x0000.

Source files
------------

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - default raster constants and delay-line flag type for video_timing
package video_timing_pkg;

    // 320x240 at 15 kHz: 40x30 cells of 8x8
    localparam int DEF_CE_DIV     = 2;
    localparam int DEF_H_VISIBLE  = 320;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 32;
    localparam int DEF_H_BP       = 32;
    localparam int DEF_V_VISIBLE  = 240;
    localparam int DEF_V_FP       = 3;
    localparam int DEF_V_SYNC     = 4;
    localparam int DEF_V_BP       = 15;
    localparam int DEF_SYNC_POL   = 0;
    localparam int DEF_PIPE_DELAY = 2;

    localparam int DEF_H_TOTAL      = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL      = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    // Sync/blank flags carried through the delay line; sync is active-high here,
    // output polarity is applied only at the top-level pins.
    typedef struct packed {
        logic hs;
        logic vs;
        logic hb;
        logic vb;
    } sync_flags_t;

    localparam sync_flags_t FLAGS_RESET = '{hs: 1'b0, vs: 1'b0, hb: 1'b1, vb: 1'b1};

    // Half-open window test lo <= v < hi on 10-bit values
    function automatic logic in_window(input logic [9:0] v, input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/video_timing_delay.sv
// rtl/video_timing_delay.sv - sync_delay: DEPTH-stage flag shift register advancing on ce
//
// Ports: clk, reset (async active-low), ce (advance enable),
//        din (flags entering), dout (flags DEPTH ce ticks later; din when DEPTH = 0).
module sync_delay
    import video_timing_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter sync_flags_t RESET_VAL = FLAGS_RESET
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  sync_flags_t din,
    output sync_flags_t dout
);

    if (DEPTH == 0) begin : g_bypass
        assign dout = din;
    end else begin : g_pipe
        sync_flags_t stage [DEPTH];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage[i] <= RESET_VAL;
                end
            end else if (ce) begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/video_timing.sv
// rtl/video_timing.sv - raster timing generator: pixel enable, hcnt/vcnt, delayed sync/blank/de, frame count, vblank irq
//
// Ports: clk; reset (async active-low); ce_pix (pixel enable, 1 clk wide);
//        hcnt/vcnt (9-bit raster counters); hsync/vsync (delayed, polarity SYNC_POL);
//        hblank/vblank/de (delayed); frame (16-bit frame counter);
//        vblank_irq (one-clk strobe when vcnt enters V_VISIBLE, not delayed).
module video_timing
    import video_timing_pkg::*;
#(
    parameter int CE_DIV     = DEF_CE_DIV,
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int SYNC_POL   = DEF_SYNC_POL,
    parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ce_pix,
    output logic [8:0]  hcnt,
    output logic [8:0]  vcnt,
    output logic        hsync,
    output logic        vsync,
    output logic        hblank,
    output logic        vblank,
    output logic        de,
    output logic [15:0] frame,
    output logic        vblank_irq
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    if (H_TOTAL > 512) begin : g_bad_h_total
        $error("video_timing: H_TOTAL %0d exceeds 512", H_TOTAL);
    end
    if (V_TOTAL > 512) begin : g_bad_v_total
        $error("video_timing: V_TOTAL %0d exceeds 512", V_TOTAL);
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_pipe
        $error("video_timing: PIPE_DELAY %0d outside 0..7", PIPE_DELAY);
    end
    if (CE_DIV < 1) begin : g_bad_div
        $error("video_timing: CE_DIV %0d must be at least 1", CE_DIV);
    end

    // 10-bit thresholds so porch/sync sums cannot wrap against 9-bit counters
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
    localparam logic [9:0] H_SS    = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SE    = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_SS    = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SE    = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0] V_ENTRY = 10'(V_VISIBLE - 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [8:0]       h_next;
    logic [8:0]       v_next;
    logic             h_wrap;
    logic             frame_wrap;
    logic             irq_next;
    sync_flags_t      raw_next;
    sync_flags_t      raw;
    sync_flags_t      dly;

    always_comb begin
        h_next     = hcnt + 9'd1;
        v_next     = vcnt;
        h_wrap     = ({1'b0, hcnt} == H_LAST);
        frame_wrap = 1'b0;
        if (h_wrap) begin
            h_next = '0;
            if ({1'b0, vcnt} == V_LAST) begin
                v_next     = '0;
                frame_wrap = 1'b1;
            end else begin
                v_next = vcnt + 9'd1;
            end
        end
        irq_next = ce_pix && h_wrap && ({1'b0, vcnt} == V_ENTRY);

        // Flags are taken from the counter values about to be loaded, so the
        // registered flags line up with the new hcnt/vcnt.
        raw_next.hb = ({1'b0, h_next} >= H_VIS);
        raw_next.vb = ({1'b0, v_next} >= V_VIS);
        raw_next.hs = in_window({1'b0, h_next}, H_SS, H_SE);
        raw_next.vs = in_window({1'b0, v_next}, V_SS, V_SE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div        <= '0;
            ce_pix     <= 1'b0;
            hcnt       <= '0;
            vcnt       <= '0;
            frame      <= '0;
            vblank_irq <= 1'b0;
            raw        <= FLAGS_RESET;
        end else begin
            div        <= (div == DIV_LAST) ? '0 : div + 1'b1;
            ce_pix     <= (div == DIV_LAST);
            vblank_irq <= irq_next;
            if (ce_pix) begin
                hcnt <= h_next;
                vcnt <= v_next;
                raw  <= raw_next;
                if (frame_wrap) begin
                    frame <= frame + 16'd1;
                end
            end
        end
    end

    sync_delay #(
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (FLAGS_RESET)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .ce    (ce_pix),
        .din   (raw),
        .dout  (dly)
    );

    assign hsync  = (SYNC_POL != 0) ? dly.hs : ~dly.hs;
    assign vsync  = (SYNC_POL != 0) ? dly.vs : ~dly.vs;
    assign hblank = dly.hb;
    assign vblank = dly.vb;
    assign de     = ~dly.hb & ~dly.vb;

endmodule

// File: tb/tb_video_timing.sv
// tb/tb_video_timing.sv - scoreboard bench for video_timing with randomized reset placement
module tb_video_timing;

    typedef struct {
        int ce_div;
        int hv, hf, hs, hb;
        int vv, vf, vs, vb;
        int pd;
        bit pol;
    } cfg_t;

    typedef struct {
        bit ce;
        int hcnt;
        int vcnt;
        bit hsync;
        bit vsync;
        bit hblank;
        bit vblank;
        bit de;
        int frame;
        bit irq;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    // a: small raster, CE_DIV 2, PIPE_DELAY 2, active-low sync
    // b: small raster, CE_DIV 1, PIPE_DELAY 0, active-high sync
    // c: default raster, CE_DIV 2, PIPE_DELAY 0
    logic       ce_a, hs_a, vs_a, hb_a, vb_a, de_a, irq_a;
    logic [8:0] hc_a, vc_a;
    logic [15:0] fr_a;
    logic       ce_b, hs_b, vs_b, hb_b, vb_b, de_b, irq_b;
    logic [8:0] hc_b, vc_b;
    logic [15:0] fr_b;
    logic       ce_c, hs_c, vs_c, hb_c, vb_c, de_c, irq_c;
    logic [8:0] hc_c, vc_c;
    logic [15:0] fr_c;

    video_timing #(
        .CE_DIV(2), .H_VISIBLE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_VISIBLE(10), .V_FP(2), .V_SYNC(3), .V_BP(4), .SYNC_POL(0), .PIPE_DELAY(2)
    ) dut_a (
        .clk(clk), .reset(reset), .ce_pix(ce_a), .hcnt(hc_a), .vcnt(vc_a),
        .hsync(hs_a), .vsync(vs_a), .hblank(hb_a), .vblank(vb_a), .de(de_a),
        .frame(fr_a), .vblank_irq(irq_a)
    );

    video_timing #(
        .CE_DIV(1), .H_VISIBLE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_VISIBLE(10), .V_FP(2), .V_SYNC(3), .V_BP(4), .SYNC_POL(1), .PIPE_DELAY(0)
    ) dut_b (
        .clk(clk), .reset(reset), .ce_pix(ce_b), .hcnt(hc_b), .vcnt(vc_b),
        .hsync(hs_b), .vsync(vs_b), .hblank(hb_b), .vblank(vb_b), .de(de_b),
        .frame(fr_b), .vblank_irq(irq_b)
    );

    video_timing #(
        .CE_DIV(2), .PIPE_DELAY(0)
    ) dut_c (
        .clk(clk), .reset(reset), .ce_pix(ce_c), .hcnt(hc_c), .vcnt(vc_c),
        .hsync(hs_c), .vsync(vs_c), .hblank(hb_c), .vblank(vb_c), .de(de_c),
        .frame(fr_c), .vblank_irq(irq_c)
    );

    cfg_t cfg_a = '{ce_div: 2, hv: 20, hf: 3, hs: 4, hb: 5, vv: 10, vf: 2, vs: 3, vb: 4, pd: 2, pol: 1'b0};
    cfg_t cfg_b = '{ce_div: 1, hv: 20, hf: 3, hs: 4, hb: 5, vv: 10, vf: 2, vs: 3, vb: 4, pd: 0, pol: 1'b1};
    cfg_t cfg_c = '{ce_div: 2, hv: 320, hf: 16, hs: 32, hb: 32, vv: 240, vf: 3, vs: 4, vb: 15, pd: 0, pol: 1'b0};

    obs_t q_a[$];
    obs_t q_b[$];
    obs_t q_c[$];

    int     n_vec = 0;
    int     n_err = 0;
    longint n_edge = 0;   // clk edges since reset release

    // Pixel ticks completed after edge n: ce_pix is first high after edge
    // CE_DIV, and each high ce_pix is consumed by the following edge.
    function automatic longint ticks(cfg_t c, longint n);
        return (n >= 1) ? (n - 1) / c.ce_div : 0;
    endfunction

    // Expected outputs after edge n, derived from raster position arithmetic.
    // Flags shown at tick t belong to raster tick t - PIPE_DELAY; tick 0 and
    // earlier show the reset flags.
    function automatic obs_t model(cfg_t c, longint n, bit in_rst);
        obs_t   e;
        longint t, k, ht, vt, hk, vk;
        bit     fhb, fvb, fhs, fvs;
        ht = c.hv + c.hf + c.hs + c.hb;
        vt = c.vv + c.vf + c.vs + c.vb;
        e.ce = 0; e.hcnt = 0; e.vcnt = 0; e.frame = 0; e.irq = 0;
        fhb = 1; fvb = 1; fhs = 0; fvs = 0;
        if (!in_rst && n > 0) begin
            e.ce    = (n >= c.ce_div) && (n % c.ce_div == 0);
            t       = ticks(c, n);
            e.hcnt  = int'(t % ht);
            e.vcnt  = int'((t / ht) % vt);
            e.frame = int'((t / (ht * vt)) % 65536);
            e.irq   = (ticks(c, n) != ticks(c, n - 1)) && e.hcnt == 0 && e.vcnt == c.vv;
            k = t - c.pd;
            if (k >= 1) begin
                hk  = k % ht;
                vk  = (k / ht) % vt;
                fhb = hk >= c.hv;
                fvb = vk >= c.vv;
                fhs = (hk >= c.hv + c.hf) && (hk < c.hv + c.hf + c.hs);
                fvs = (vk >= c.vv + c.vf) && (vk < c.vv + c.vf + c.vs);
            end
        end
        e.hblank = fhb;
        e.vblank = fvb;
        e.de     = !fhb && !fvb;
        e.hsync  = c.pol ? fhs : !fhs;
        e.vsync  = c.pol ? fvs : !fvs;
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at t=%0t edge %0d: got %0d expected %0d", name, $time, n_edge, act, exp);
        end
    endtask

    task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
        chk({tag, ".ce_pix"},     a.ce,     e.ce);
        chk({tag, ".hcnt"},       a.hcnt,   e.hcnt);
        chk({tag, ".vcnt"},       a.vcnt,   e.vcnt);
        chk({tag, ".hsync"},      a.hsync,  e.hsync);
        chk({tag, ".vsync"},      a.vsync,  e.vsync);
        chk({tag, ".hblank"},     a.hblank, e.hblank);
        chk({tag, ".vblank"},     a.vblank, e.vblank);
        chk({tag, ".de"},         a.de,     e.de);
        chk({tag, ".frame"},      a.frame,  e.frame);
        chk({tag, ".vblank_irq"}, a.irq,    e.irq);
    endtask

    // Monitor: compare on the falling edge, away from the active edge
    always @(negedge clk) begin
        obs_t a, e;
        while (q_a.size() > 0) begin
            e = q_a.pop_front();
            a = '{ce: ce_a, hcnt: int'(hc_a), vcnt: int'(vc_a), hsync: hs_a, vsync: vs_a,
                  hblank: hb_a, vblank: vb_a, de: de_a, frame: int'(fr_a), irq: irq_a};
            cmp_obs("a", a, e);
        end
        while (q_b.size() > 0) begin
            e = q_b.pop_front();
            a = '{ce: ce_b, hcnt: int'(hc_b), vcnt: int'(vc_b), hsync: hs_b, vsync: vs_b,
                  hblank: hb_b, vblank: vb_b, de: de_b, frame: int'(fr_b), irq: irq_b};
            cmp_obs("b", a, e);
        end
        while (q_c.size() > 0) begin
            e = q_c.pop_front();
            a = '{ce: ce_c, hcnt: int'(hc_c), vcnt: int'(vc_c), hsync: hs_c, vsync: vs_c,
                  hblank: hb_c, vblank: vb_c, de: de_c, frame: int'(fr_c), irq: irq_c};
            cmp_obs("c", a, e);
        end
    end

    task automatic push_expect();
        q_a.push_back(model(cfg_a, n_edge, !reset));
        q_b.push_back(model(cfg_b, n_edge, !reset));
        q_c.push_back(model(cfg_c, n_edge, !reset));
    endtask

    // Reset is dropped 1 ns after an edge, so the following compare checks the
    // asynchronous clear with no clk edge in between.
    task automatic apply_reset(input int cyc);
        @(posedge clk); #1;
        reset  = 1'b0;
        n_edge = 0;
        push_expect();
        repeat (cyc - 1) begin
            @(posedge clk); #1;
            push_expect();
        end
        @(posedge clk); #1;
        reset = 1'b1;
        push_expect();
    endtask

    task automatic run(input int cyc);
        repeat (cyc) begin
            @(posedge clk); #1;
            n_edge++;
            push_expect();
        end
    endtask

    initial begin
        reset = 1'b0;
        apply_reset(3);
        // two full frames of the small raster at CE_DIV 2, plus a partial line of c
        run(2 * 608 * 2 + 100);
        apply_reset($urandom_range(4, 1));
        run($urandom_range(900, 200));
        apply_reset($urandom_range(4, 1));
        run(1300);
        for (int i = 0; i < 4; i++) begin
            apply_reset($urandom_range(4, 1));
            run($urandom_range(400, 50));
        end
        apply_reset(2);
        run(20);
        @(negedge clk); #1;
        chk("queue_drain", q_a.size() + q_b.size() + q_c.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
